// File: rtl/fp8_pkg.sv
// Shared e4m3 constants, lookup tables and stage bundles
// for the fp8 log2 pipeline.
package fp8_pkg;

  localparam int E4M3_BIAS = 7;
  localparam logic [7:0] E4M3_NAN = 8'h7F;
  localparam int GRS_W = 3;
  localparam int SIG_W = 4 + GRS_W;

  // Element 0 is the rightmost entry
  localparam logic [7:0][7:0] MANT_LUT = {
    8'h37, 8'h35, 8'h33, 8'h31,
    8'h2F, 8'h2A, 8'h23, 8'h00
  };
  localparam logic [7:0][7:0] SUB_LUT = {
    8'hCC, 8'hCD, 8'hCD, 8'hCE,
    8'hCF, 8'hD0, 8'hD1, 8'h00
  };

  typedef struct packed {
    logic       sign;
    logic [3:0] exp;
    logic [3:0] sig;
  } e4m3_unp_t;

  typedef struct packed {
    logic       bypass;
    logic       err;
    logic [7:0] res;
    logic [7:0] a;
    logic [7:0] b;
  } s1_t;

  typedef struct packed {
    logic             bypass;
    logic             err;
    logic [7:0]       res;
    logic             sign;
    logic [3:0]       exp;
    logic [SIG_W-1:0] lsig;
    logic [SIG_W-1:0] ssig;
    logic             sub;
  } s2_t;

  function automatic e4m3_unp_t e4m3_unpack(
    input logic [7:0] v
  );
    e4m3_unp_t u;
    u.sign = v[7];
    u.exp  = (v[6:3] == 4'd0) ? 4'd1 : v[6:3];
    u.sig  = {v[6:3] != 4'd0, v[2:0]};
    return u;
  endfunction

  function automatic logic [2:0] lzc7(
    input logic [6:0] v
  );
    logic [2:0] n;
    n = 3'd7;
    for (int i = 0; i < 7; i++)
      if (v[i]) n = 3'(6 - i);
    return n;
  endfunction

endpackage

// File: rtl/fp8_e4m3_add_pipe.sv
// Two-stage e4m3 adder (align, then add/normalise/RNE)
// carrying the bypass/err sideband alongside.
module fp8_e4m3_add_pipe
  import fp8_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv2,
  input  logic       adv3,
  input  logic       v1,
  input  s1_t        s1,
  output logic       v2,
  output logic       v3,
  output logic [7:0] out_data,
  output logic       out_err
);

  e4m3_unp_t ua, ub;
  logic a_ge;
  logic [3:0] sexp, sg, dexp;
  logic [2*SIG_W-1:0] wide;
  s2_t s2_d, s2;

  always_comb begin
    ua   = e4m3_unpack(s1.a);
    ub   = e4m3_unpack(s1.b);
    a_ge = s1.a[6:0] >= s1.b[6:0];
    sexp = a_ge ? ub.exp : ua.exp;
    sg   = a_ge ? ub.sig : ua.sig;
    s2_d = '0;
    s2_d.bypass = s1.bypass;
    s2_d.err    = s1.err;
    s2_d.res    = s1.res;
    s2_d.sign   = a_ge ? ua.sign : ub.sign;
    s2_d.exp    = a_ge ? ua.exp : ub.exp;
    s2_d.lsig   = {a_ge ? ua.sig : ub.sig,
                   {GRS_W{1'b0}}};
    dexp = s2_d.exp - sexp;
    wide = {sg, {GRS_W{1'b0}}, {SIG_W{1'b0}}}
           >> dexp;
    // Far shifts keep only the sticky bit
    s2_d.ssig = (dexp >= 4'(SIG_W - 1))
      ? {{(SIG_W-1){1'b0}}, |sg}
      : {wide[2*SIG_W-1:SIG_W+1], |wide[SIG_W:0]};
    s2_d.sub = ua.sign ^ ub.sign;
  end

  logic [SIG_W:0]   sum;
  logic [SIG_W-1:0] nrm;
  logic [2:0]       lz;
  logic [4:0]       e_n, e_r, rsig;
  logic             up;
  logic [7:0]       res_d;

  always_comb begin
    sum = s2.sub
      ? {1'b0, s2.lsig} - {1'b0, s2.ssig}
      : {1'b0, s2.lsig} + {1'b0, s2.ssig};
    lz = lzc7(sum[SIG_W-1:0]);
    if (sum[SIG_W]) begin
      nrm = {sum[SIG_W:2], sum[1] | sum[0]};
      e_n = {1'b0, s2.exp} + 5'd1;
    end else begin
      nrm = sum[SIG_W-1:0] << lz;
      e_n = {1'b0, s2.exp} - {2'b00, lz};
    end
    up   = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
    rsig = {1'b0, nrm[SIG_W-1:GRS_W]}
         + {4'b0000, up};
    e_r  = rsig[4] ? e_n + 5'd1 : e_n;
    res_d = {s2.sign, e_r[3:0],
             rsig[4] ? 3'b000 : rsig[2:0]};
    if (sum == '0) res_d = 8'h00;
    if (s2.bypass) res_d = s2.res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2       <= 1'b0;
      v3       <= 1'b0;
      s2       <= '0;
      out_data <= '0;
      out_err  <= 1'b0;
    end else begin
      if (adv2) begin
        v2 <= v1;
        if (v1) s2 <= s2_d;
      end
      if (adv3) begin
        v3 <= v2;
        if (v2) begin
          out_data <= res_d;
          out_err  <= s2.err;
        end
      end
    end
  end

  a_no_x: assert property (
    @(posedge clk) disable iff (!rst_n)
    v3 |-> !$isunknown(out_data));

  a_no_inf: assert property (
    @(posedge clk) disable iff (!rst_n)
    (v3 && !out_err) |-> out_data[6:3] != 4'hF);

  a_range: assert property (
    @(posedge clk) disable iff (!rst_n)
    (v2 && !s2.bypass && sum != '0) |->
    (e_r >= 5'd1 && e_r <= 5'd14 &&
     (rsig[4] || rsig[3])));

endmodule

// File: rtl/fp8_int_to_float8.sv
// Exact signed small-integer to e4m3 converter
// used for the unbiased exponent term.
module fp8_int_to_float8
  import fp8_pkg::*;
(
  input  logic signed [4:0] val,
  output logic        [7:0] fp
);

  logic [4:0] mag;
  logic       s;

  always_comb begin
    s   = val[4];
    mag = s ? $unsigned(-val) : $unsigned(val);
    fp  = '0;
    unique case (1'b1)
      mag[4]:
        fp = {s, 4'(E4M3_BIAS + 4), mag[3:1]};
      mag[4:3] == 2'b01:
        fp = {s, 4'(E4M3_BIAS + 3), mag[2:0]};
      mag[4:2] == 3'b001:
        fp = {s, 4'(E4M3_BIAS + 2), mag[1:0], 1'b0};
      mag[4:1] == 4'b0001:
        fp = {s, 4'(E4M3_BIAS + 1), mag[0], 2'b00};
      mag == 5'd1:
        fp = {s, 4'(E4M3_BIAS), 3'b000};
      default:
        fp = '0;
    endcase
  end

endmodule

// File: rtl/fp8_log2_pipe.sv
// Three-stage pipelined log2 of an e4m3 operand:
// (E-7) + log2(1+m/8), summed with RNE, e4m3 out.
module fp8_log2_pipe
  import fp8_pkg::*;
#(
  parameter int FLOAT8_TYPE = 0,
  parameter int EXP_BIAS    = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_err
);

  if (FLOAT8_TYPE != 0 || EXP_BIAS != E4M3_BIAS)
  begin : g_bad_cfg
    $error("fp8_log2_pipe: only e4m3, bias 7");
  end

  logic v1, v2, v3;
  logic adv1, adv2, adv3;
  logic [3:0] e;
  logic [2:0] m;
  logic is_spec, is_sub;
  logic signed [4:0] e_unb;
  logic [7:0] a_fp;
  s1_t s1, s1_d;

  assign adv3 = !v3 | out_ready;
  assign adv2 = !v2 | adv3;
  assign adv1 = !v1 | adv2;
  assign in_ready  = adv1;
  assign out_valid = v3;

  assign e = in_data[6:3];
  assign m = in_data[2:0];
  assign e_unb =
    $signed({1'b0, e} - 5'(E4M3_BIAS));

  fp8_int_to_float8 u_exp (
    .val (e_unb),
    .fp  (a_fp)
  );

  always_comb begin
    is_spec = in_data[6:0] == 7'd0
            | in_data[7]
            | &in_data[6:0];
    is_sub  = !is_spec & (e == 4'd0);
    s1_d        = '0;
    s1_d.a      = a_fp;
    s1_d.b      = MANT_LUT[m];
    unique case (1'b1)
      is_spec: begin
        s1_d.bypass = 1'b1;
        s1_d.err    = 1'b1;
        s1_d.res    = E4M3_NAN;
        s1_d.a      = '0;
        s1_d.b      = '0;
      end
      is_sub: begin
        s1_d.bypass = 1'b1;
        s1_d.res    = SUB_LUT[m];
        s1_d.a      = '0;
        s1_d.b      = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      s1 <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) s1 <= s1_d;
    end
  end

  fp8_e4m3_add_pipe u_add (
    .clk      (clk),
    .rst_n    (rst_n),
    .adv2     (adv2),
    .adv3     (adv3),
    .v1       (v1),
    .s1       (s1),
    .v2       (v2),
    .v3       (v3),
    .out_data (out_data),
    .out_err  (out_err)
  );

endmodule

// File: tb/tb_fp8_log2_pipe.sv
// Scoreboard bench for fp8_log2_pipe against a
// real-arithmetic log2 reference with e4m3 RNE.
module tb_fp8_log2_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] in_data = 8'h00;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [7:0] out_data;
  logic out_err;

  always #5 clk = ~clk;

  fp8_log2_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  typedef struct {
    logic [7:0] d;
    logic       e;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_in = 0;
  int n_out = 0;
  int mode = 0;
  bit lat_chk = 0;
  bit stall_prev = 0;
  logic [8:0] held;
  logic [7:0] last_out = 8'h00;
  logic [7:0] dir [12] = '{
    8'h38, 8'h40, 8'h30, 8'h3C, 8'h34, 8'h7E,
    8'h00, 8'h80, 8'hC0, 8'h7F, 8'h01, 8'h07};

  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real log2r(input real x);
    return $ln(x) / $ln(2.0);
  endfunction

  function automatic logic [7:0] fp8_rne(input real x);
    real a, q, fr;
    int e, fl;
    logic s;
    s = (x < 0.0);
    a = s ? -x : x;
    if (a == 0.0) return 8'h00;
    e = -9;
    while (e < 8 && a >= pow2(e + 1)) e++;
    q  = a / pow2(e) * 8.0;
    fl = int'($floor(q));
    fr = q - fl;
    if (fr > 0.5 || (fr == 0.5 && fl[0])) fl++;
    if (fl == 16) begin
      fl = 8;
      e++;
    end
    return {s, 4'(e + 7), 3'(fl - 8)};
  endfunction

  function automatic real fp8_val(input logic [7:0] c);
    real v;
    int ex, mt;
    ex = int'(c[6:3]);
    mt = int'(c[2:0]);
    if (ex == 0) v = mt / 8.0 * pow2(-6);
    else v = (1.0 + mt / 8.0) * pow2(ex - 7);
    return c[7] ? -v : v;
  endfunction

  function automatic exp_t ref_model(input logic [7:0] v);
    exp_t r;
    int ex, mt;
    real b;
    ex = int'(v[6:3]);
    mt = int'(v[2:0]);
    r.cyc = 0;
    r.e = 1'b0;
    if (v[6:0] == 7'd0 || v[7] || (ex == 15 && mt == 7)) begin
      r.d = 8'h7F;
      r.e = 1'b1;
    end else if (ex == 0) begin
      r.d = fp8_rne(-9.0 + log2r(mt));
    end else begin
      b = fp8_val(fp8_rne(log2r(1.0 + mt / 8.0)));
      r.d = fp8_rne(real'(ex - 7) + b);
    end
    return r;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    exp_t x;
    if (!rst_n) begin
      sb.delete();
      n_in = 0;
      n_out = 0;
      stall_prev = 0;
    end else begin
      chk("in_ready", 32'(in_ready),
          32'(!((n_in - n_out) == 3 && !out_ready)));
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'({out_err, out_data}),
            32'(held));
      end
      if (out_valid) begin
        if (out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %0h expected none",
                     out_data);
          end else begin
            x = sb.pop_front();
            chk("out_data", 32'(out_data), 32'(x.d));
            chk("out_err", 32'(out_err), 32'(x.e));
            if (lat_chk)
              chk("latency", 32'(cyc - x.cyc), 32'd3);
          end
          last_out = out_data;
          n_out++;
        end
        stall_prev = !out_ready;
        held = {out_err, out_data};
      end else begin
        stall_prev = 0;
      end
      if (in_valid && in_ready) begin
        x = ref_model(in_data);
        x.cyc = cyc;
        sb.push_back(x);
        n_in++;
      end
    end
  end

  task automatic send(input logic [7:0] v);
    int t;
    in_valid = 1'b1;
    in_data = v;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 300);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    lat_chk = 1;
    foreach (dir[i]) send(dir[i]);
    drain();
    lat_chk = 0;

    mode = 1;
    repeat (8) send(8'($urandom));
    fork
      repeat (4) send(8'($urandom));
      begin
        repeat (2) @(posedge clk);
        mode = 2;
        repeat (5) @(posedge clk);
        mode = 1;
      end
    join
    drain();

    mode = 2;
    repeat (3) send(8'($urandom_range(8'h38, 8'h77)));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_data", 32'(out_data), 32'd0);
    chk("async_rst_err", 32'(out_err), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mode = 0;
    @(posedge clk);
    #1;
    send(8'h40);
    drain();
    chk("post_reset_out", 32'(last_out), 32'h38);

    lat_chk = 1;
    for (int i = 0; i < 256; i++) send(8'(i));
    drain();
    lat_chk = 0;

    mode = 1;
    repeat (300) begin
      send(8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
